sfx_speaker_arbiter: RTL and testbench
======================================

// Module: sfx_speaker_arbiter
// PURPOSE
// - Shares the single 1-bit speaker output between the background theme and two player gun-shot tones.
// - A shot request takes the speaker for SFX_FRAMES video frames. A request from the other player is
//   held pending, one deep per player, and served when the current shot expires.
// - Replaces the ad-hoc priority mux inside the VGA game loop. Sits between the tone generators and the speaker pin.
// PARAMETERS
// - SFX_FRAMES  30  frames a gun tone owns the speaker (1..2**CNT_W-1)
// - CNT_W       8   width of the frame down-counter
// PORTS
// - clk50mhz    in   1      system clock
// - reset       in   1      synchronous, active-high
// - frame_tick  in   1      1-cycle pulse per video frame (vcount wrap)
// - shot_req    in   2      1-cycle shot pulse; bit0 = player 0, bit1 = player 1
// - theme_in    in   1      theme music square wave
// - gun_in      in   2      gun tone square waves, per player
// - sound       out  1      registered speaker drive
// - grant       out  2      one-hot owner of the speaker; 00 = theme
// - pending     out  2      queued shot per player
// - sfx_cnt     out  CNT_W  remaining frames of the current shot
// BEHAVIOUR
// - Reset values: sound=0, grant=00, pending=00, sfx_cnt=0, state=THEME, rr_last=1 (player 0 wins first tie).
//   Reset mid-playback aborts the shot and drops all pending requests.
// - States: THEME, SFX0, SFX1. grant mirrors the state: 00, 01, 10.
// - Output mux: sound <= theme_in in THEME, gun_in[0] in SFX0, gun_in[1] in SFX1.
//   The mux uses the state before the edge, so sound lags a state change by 1 cycle.
// - THEME:
//   - If exactly one shot_req bit is set, go to SFXn next cycle and load sfx_cnt=SFX_FRAMES.
//   - If both bits are set, grant the player != rr_last and set pending for the other.
// - SFXn:
//   - shot_req[n] again: retrigger, reload sfx_cnt=SFX_FRAMES, no pending set.
//   - shot_req[other]: set pending[other]. A second request while pending is already set is absorbed.
//   - Each frame_tick decrements sfx_cnt.
//   - The tick that takes sfx_cnt 1->0 is expiry; on that same edge rr_last<=n.
//   - On expiry with pending[other] set: go to SFXother, clear that pending bit, load SFX_FRAMES.
//   - On expiry with no pending: go to THEME.
// - Priority within one cycle: reset > load/retrigger > frame_tick decrement.
//   A tick coinciding with a load is ignored, so sfx_cnt=SFX_FRAMES after that edge.
// - shot_req arriving on the expiry cycle:
//   - shot_req[n]: treated as a retrigger; stay in SFXn.
//   - shot_req[other]: goes straight to SFXother, the same as if it had been pending.
// - sfx_cnt never wraps: a decrement is blocked at 0. In THEME sfx_cnt holds 0.
// - Shot duration is exactly SFX_FRAMES frame_ticks after the load edge. No dependency on the pixel position.
// - shot_req is edge-free: pulses are taken as given. A level input held high re-triggers every cycle,
//   so the caller supplies pulses.
// STRUCTURE
// - Shared package: state encodings ST_THEME/ST_SFX0/ST_SFX1, SFX_FRAMES_DEF=30, the GRANT_NONE constant.
// - One sub-module, sfx_frame_timer: load / tick / zero-flag down-counter (CNT_W, load value), used per grant.
// - The FSM, pending flags, rr_last and the output register stay in the top level.
// TESTING
// - T1: single shot_req=01, then 30 frame_ticks -> grant=01 for ticks 1..29; back to 00 on tick 30;
//   sound follows gun_in[0], then theme_in, each 1 cycle late.
// - T2: shot_req=11 after reset -> grant=01, pending=10. After 30 ticks -> grant=10, pending=00.
//   A second 11 later -> player 0 gets it (rr_last=1).
// - T3: in SFX0 with sfx_cnt=5, pulse shot_req=01 -> sfx_cnt=30, pending unchanged, grant stays 01.
// - T4: shot_req=10 on the same cycle as a frame_tick in THEME -> grant=10, sfx_cnt=30, not 29.
// - T5: in SFX1 with pending=01, assert reset for 1 cycle -> grant=00, pending=00, sfx_cnt=0, sound=0.
//   Theme resumes on the next cycle.
// - T6: in SFX0 at expiry tick with shot_req=10 the same cycle -> grant=10 next cycle, sfx_cnt=30, no THEME gap.

Source files
------------

// File: rtl/sfx_speaker_arbiter_pkg.sv
// Shared encodings for the speaker arbiter: FSM states, which double as the
// one-hot grant vector, plus the default shot length.
package sfx_speaker_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_THEME = 2'b00,
    ST_SFX0  = 2'b01,
    ST_SFX1  = 2'b10
  } sfx_state_e;

  localparam int         SFX_FRAMES_DEF = 30;
  localparam logic [1:0] GRANT_NONE     = 2'b00;

  // Maps a player index to the state that grants that player the speaker.
  function automatic sfx_state_e sfx_state_of(input logic player);
    return player ? ST_SFX1 : ST_SFX0;
  endfunction

endpackage

// File: rtl/sfx_frame_timer.sv
// Frame down-counter for the active shot: load has priority over tick, and a
// decrement is blocked at zero so the count never wraps.
module sfx_frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk50mhz,
  input  logic             reset,
  input  logic             load,
  input  logic             tick,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             one
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign one  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sfx_speaker_arbiter.sv
// Shares the 1-bit speaker between the theme music and two players' gun
// tones; a shot owns the speaker for SFX_FRAMES frames, others queue one deep.
module sfx_speaker_arbiter
  import sfx_speaker_arbiter_pkg::*;
#(
  parameter int SFX_FRAMES = SFX_FRAMES_DEF,
  parameter int CNT_W      = 8
) (
  input  logic             clk50mhz,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [1:0]       shot_req,
  input  logic             theme_in,
  input  logic [1:0]       gun_in,
  output logic             sound,
  output logic [1:0]       grant,
  output logic [1:0]       pending,
  output logic [CNT_W-1:0] sfx_cnt
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SFX_FRAMES);

  sfx_state_e state_q, state_d;
  logic [1:0] pending_q, pending_d;
  logic       rr_last_q, rr_last_d;
  logic       sound_q, sound_d;

  logic       tmr_load;
  logic       tmr_tick;
  logic       tmr_zero;
  logic       tmr_one;
  logic       own_idx;
  logic       oth_idx;
  logic       expiring;

  assign own_idx  = (state_q == ST_SFX1);
  assign oth_idx  = ~own_idx;
  assign tmr_tick = frame_tick && (state_q != ST_THEME) && !tmr_zero;
  assign expiring = frame_tick && tmr_one;

  sfx_frame_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk50mhz (clk50mhz),
    .reset    (reset),
    .load     (tmr_load),
    .tick     (tmr_tick),
    .load_val (LOAD_VAL),
    .cnt      (sfx_cnt),
    .zero     (tmr_zero),
    .one      (tmr_one)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rr_last_d = rr_last_q;
    tmr_load  = 1'b0;
    case (state_q)
      ST_THEME: begin
        case (shot_req)
          2'b01: begin
            state_d  = ST_SFX0;
            tmr_load = 1'b1;
          end
          2'b10: begin
            state_d  = ST_SFX1;
            tmr_load = 1'b1;
          end
          2'b11: begin
            // Tie goes to the player who did not play last; the loser queues.
            state_d              = sfx_state_of(~rr_last_q);
            pending_d[rr_last_q] = 1'b1;
            tmr_load             = 1'b1;
          end
          default: ;
        endcase
      end
      ST_SFX0, ST_SFX1: begin
        if (shot_req[own_idx]) begin
          tmr_load = 1'b1;
          if (shot_req[oth_idx]) begin
            pending_d[oth_idx] = 1'b1;
          end
        end else if (expiring) begin
          rr_last_d = own_idx;
          // A fresh request from the other player on the expiry edge counts as pending.
          if (pending_q[oth_idx] || shot_req[oth_idx]) begin
            state_d            = sfx_state_of(oth_idx);
            pending_d[oth_idx] = 1'b0;
            tmr_load           = 1'b1;
          end else begin
            state_d = ST_THEME;
          end
        end else if (shot_req[oth_idx]) begin
          pending_d[oth_idx] = 1'b1;
        end
      end
      default: begin
        state_d = ST_THEME;
      end
    endcase
  end

  always_comb begin
    case (state_q)
      ST_SFX0: sound_d = gun_in[0];
      ST_SFX1: sound_d = gun_in[1];
      default: sound_d = theme_in;
    endcase
  end

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      state_q   <= ST_THEME;
      pending_q <= GRANT_NONE;
      rr_last_q <= 1'b1;
      sound_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_last_q <= rr_last_d;
      sound_q   <= sound_d;
    end
  end

  assign sound   = sound_q;
  assign grant   = state_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_sfx_speaker_arbiter.sv
// Bench for sfx_speaker_arbiter: directed scenarios then random traffic, all
// checked against a player-level reference model of the speaker ownership.
module tb_sfx_speaker_arbiter;

  localparam int F     = 30;
  localparam int CNT_W = 8;

  logic             clk50mhz = 1'b0;
  logic             reset;
  logic             frame_tick;
  logic [1:0]       shot_req;
  logic             theme_in;
  logic [1:0]       gun_in;
  logic             sound;
  logic [1:0]       grant;
  logic [1:0]       pending;
  logic [CNT_W-1:0] sfx_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: owner is -1 for theme or a player number; rem = frames left.
  int owner;
  int rem;
  int last_player;
  int queued [2];
  int exp_sound;

  always #10 clk50mhz = ~clk50mhz;

  sfx_speaker_arbiter #(
    .SFX_FRAMES (F),
    .CNT_W      (CNT_W)
  ) dut (
    .clk50mhz   (clk50mhz),
    .reset      (reset),
    .frame_tick (frame_tick),
    .shot_req   (shot_req),
    .theme_in   (theme_in),
    .gun_in     (gun_in),
    .sound      (sound),
    .grant      (grant),
    .pending    (pending),
    .sfx_cnt    (sfx_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    owner       = -1;
    rem         = 0;
    last_player = 1;
    queued[0]   = 0;
    queued[1]   = 0;
    exp_sound   = 0;
  endtask

  task automatic model_step(input logic [1:0] req, input logic tick);
    int me;
    int other;
    exp_sound = (owner < 0) ? int'(theme_in) : int'(gun_in[owner]);
    if (owner < 0) begin
      if (req == 2'b11) begin
        owner          = 1 - last_player;
        queued[last_player] = 1;
        rem            = F;
      end else if (req != 2'b00) begin
        owner = req[1] ? 1 : 0;
        rem   = F;
      end
    end else begin
      me    = owner;
      other = 1 - owner;
      if (req[me]) begin
        rem = F;
        if (req[other]) queued[other] = 1;
      end else if (tick && rem == 1) begin
        last_player = me;
        if (queued[other] != 0 || req[other]) begin
          owner         = other;
          queued[other] = 0;
          rem           = F;
        end else begin
          owner = -1;
          rem   = 0;
        end
      end else begin
        if (req[other]) queued[other] = 1;
        if (tick && rem > 0) rem = rem - 1;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic [1:0] req, input logic tick, input string tag);
    reset      = rst;
    shot_req   = req;
    frame_tick = tick;
    theme_in   = 1'($urandom);
    gun_in     = 2'($urandom);
    if (rst) model_reset();
    else     model_step(req, tick);
    @(posedge clk50mhz);
    #1;
    chk({tag, "_grant"}, 32'(grant), (owner < 0) ? 32'd0 : ((owner == 0) ? 32'd1 : 32'd2));
    chk({tag, "_pending"}, 32'(pending), 32'(queued[1] * 2 + queued[0]));
    chk({tag, "_sfx_cnt"}, 32'(sfx_cnt), 32'(rem));
    chk({tag, "_sound"}, 32'(sound), 32'(exp_sound));
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    shot_req   = 2'b00;
    theme_in   = 1'b0;
    gun_in     = 2'b00;
    model_reset();

    cycle(1'b1, 2'b00, 1'b0, "rst");
    cycle(1'b1, 2'b00, 1'b1, "rst");
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_cnt", 32'(sfx_cnt), 32'd0);
    chk("rst_sound", 32'(sound), 32'd0);

    // T1: single shot, full duration, return to theme
    cycle(1'b0, 2'b01, 1'b0, "t1_load");
    chk("t1_grant_load", 32'(grant), 32'd1);
    chk("t1_cnt_load", 32'(sfx_cnt), 32'd30);
    for (int i = 1; i <= F; i++) begin
      cycle(1'b0, 2'b00, 1'b1, "t1_tick");
      chk("t1_grant_tick", 32'(grant), (i < F) ? 32'd1 : 32'd0);
    end
    cycle(1'b0, 2'b00, 1'b0, "t1_tail");

    // T2: simultaneous shots, queued player served, round robin
    cycle(1'b1, 2'b00, 1'b0, "t2_rst");
    cycle(1'b0, 2'b11, 1'b0, "t2_both");
    chk("t2_grant0", 32'(grant), 32'd1);
    chk("t2_pend0", 32'(pending), 32'd2);
    for (int i = 0; i < F; i++) cycle(1'b0, 2'b00, 1'b1, "t2_run0");
    chk("t2_grant1", 32'(grant), 32'd2);
    chk("t2_pend1", 32'(pending), 32'd0);
    chk("t2_cnt1", 32'(sfx_cnt), 32'd30);
    for (int i = 0; i < F; i++) cycle(1'b0, 2'b00, 1'b1, "t2_run1");
    chk("t2_theme", 32'(grant), 32'd0);
    cycle(1'b0, 2'b11, 1'b0, "t2_both2");
    chk("t2_grant2", 32'(grant), 32'd1);
    chk("t2_pend2", 32'(pending), 32'd2);

    // T3: retrigger in SFX0 at sfx_cnt=5
    for (int i = 0; i < F - 5; i++) cycle(1'b0, 2'b00, 1'b1, "t3_run");
    chk("t3_cnt5", 32'(sfx_cnt), 32'd5);
    cycle(1'b0, 2'b01, 1'b1, "t3_retrig");
    chk("t3_cnt", 32'(sfx_cnt), 32'd30);
    chk("t3_pend", 32'(pending), 32'd2);
    chk("t3_grant", 32'(grant), 32'd1);

    // T4: request coinciding with a tick in THEME
    cycle(1'b1, 2'b00, 1'b0, "t4_rst");
    cycle(1'b0, 2'b10, 1'b1, "t4_req");
    chk("t4_grant", 32'(grant), 32'd2);
    chk("t4_cnt", 32'(sfx_cnt), 32'd30);

    // T5: reset mid-playback with a queued request
    cycle(1'b0, 2'b01, 1'b1, "t5_queue");
    chk("t5_pend", 32'(pending), 32'd1);
    cycle(1'b1, 2'b00, 1'b0, "t5_rst");
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_pending", 32'(pending), 32'd0);
    chk("t5_cnt", 32'(sfx_cnt), 32'd0);
    chk("t5_sound", 32'(sound), 32'd0);
    cycle(1'b0, 2'b00, 1'b0, "t5_resume");
    chk("t5_theme", 32'(sound), 32'(theme_in));

    // T6: other player's request exactly on the expiry tick
    cycle(1'b0, 2'b01, 1'b0, "t6_load");
    for (int i = 0; i < F - 1; i++) cycle(1'b0, 2'b00, 1'b1, "t6_run");
    chk("t6_cnt1", 32'(sfx_cnt), 32'd1);
    cycle(1'b0, 2'b10, 1'b1, "t6_expire");
    chk("t6_grant", 32'(grant), 32'd2);
    chk("t6_cnt", 32'(sfx_cnt), 32'd30);
    cycle(1'b0, 2'b00, 1'b0, "t6_after");
    chk("t6_sound", 32'(sound), 32'(gun_in[1]));

    // Random traffic
    cycle(1'b1, 2'b00, 1'b0, "rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] r;
      logic       t;
      logic       rs;
      r[0] = ($urandom_range(0, 15) == 0);
      r[1] = ($urandom_range(0, 15) == 0);
      t    = 1'($urandom);
      rs   = ($urandom_range(0, 499) == 0);
      cycle(rs, r, t, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
